// File: rtl/wb_mem_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_mem_arbiter_if : one 128-bit-line wishbone link (master drives requests)
// Revision: 1.0
// ----------------------------------------------------------------------------
interface wb_mem_arbiter_if;
  logic [11:0]  ADR;
  logic [127:0] DAT_M;
  logic [15:0]  SEL;
  logic         WE;
  logic         CYC;
  logic         STB;
  logic [127:0] DAT_S;
  logic         ACK;
  logic         RTY;

  modport master (output ADR, DAT_M, SEL, WE, CYC, STB,
                  input  DAT_S, ACK, RTY);
  modport slave  (input  ADR, DAT_M, SEL, WE, CYC, STB,
                  output DAT_S, ACK, RTY);
endinterface
`default_nettype wire

// File: rtl/wb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_mem_arbiter : round-robin merge of imem/dmem wishbone onto main memory,
//                  with a per-transaction watchdog that turns hangs into RTY
// Revision: 1.0
// ----------------------------------------------------------------------------
module wb_mem_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_mem_arbiter_if.slave      imem,
  wb_mem_arbiter_if.slave      dmem,
  wb_mem_arbiter_if.master     mem
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  localparam bit         WD_EN     = (TIMEOUT != 0);
  localparam int         WD_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] WD_LAST = WD_LAST_I[CNT_W-1:0];

  logic [1:0]       state;
  logic             last;
  logic [CNT_W-1:0] wd_cnt;

  logic req_i, req_d, req_g, mem_done, wd_fire;

  assign req_i    = imem.CYC & imem.STB;
  assign req_d    = dmem.CYC & dmem.STB;
  assign req_g    = ((state == GNT_I) & req_i) | ((state == GNT_D) & req_d);
  assign mem_done = mem.ACK | mem.RTY;
  // An abort (req_g low) also suppresses the watchdog so no stray RTY escapes.
  assign wd_fire  = WD_EN & req_g & (wd_cnt == WD_LAST) & ~mem_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last   <= 1'b0;
      wd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i & (~req_d | last)) begin
            state  <= GNT_I;
            last   <= 1'b0;
            wd_cnt <= '0;
          end else if (req_d) begin
            state  <= GNT_D;
            last   <= 1'b1;
            wd_cnt <= '0;
          end
        end
        GNT_I, GNT_D: begin
          if (~req_g | mem_done | wd_fire) begin
            state <= IDLE;
          end else if (WD_EN) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem.ADR    = '0;
    mem.DAT_M  = '0;
    mem.SEL    = '0;
    mem.WE     = 1'b0;
    mem.CYC    = 1'b0;
    mem.STB    = 1'b0;
    imem.DAT_S = '0;
    imem.ACK   = 1'b0;
    imem.RTY   = 1'b0;
    dmem.DAT_S = '0;
    dmem.ACK   = 1'b0;
    dmem.RTY   = 1'b0;
    case (state)
      GNT_I: begin
        mem.ADR    = imem.ADR;
        mem.SEL    = 16'hFFFF;
        mem.CYC    = req_i & ~wd_fire;
        mem.STB    = req_i & ~wd_fire;
        imem.DAT_S = mem.DAT_S;
        imem.ACK   = mem.ACK & req_i;
        imem.RTY   = (mem.RTY & req_i) | wd_fire;
      end
      GNT_D: begin
        mem.ADR    = dmem.ADR;
        mem.DAT_M  = dmem.DAT_M;
        mem.SEL    = dmem.SEL;
        mem.WE     = dmem.WE;
        mem.CYC    = req_d & ~wd_fire;
        mem.STB    = req_d & ~wd_fire;
        dmem.DAT_S = mem.DAT_S;
        dmem.ACK   = mem.ACK & req_d;
        dmem.RTY   = (mem.RTY & req_d) | wd_fire;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_wb_mem_arbiter : random two-requester traffic against a transaction-level
//                     model of arbitration, completion and watchdog timing
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_wb_mem_arbiter;

  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  wb_mem_arbiter_if imem_bus ();
  wb_mem_arbiter_if dmem_bus ();
  wb_mem_arbiter_if mem_bus ();

  wb_mem_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk  (clk),
    .rst  (rst),
    .imem (imem_bus),
    .dmem (dmem_bus),
    .mem  (mem_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cycle;
    int           port;
    bit           ack;
    bit           rty;
    bit           wd;
    logic [127:0] data;
    logic [11:0]  adr;
    bit           we;
    logic [15:0]  sel;
    logic [127:0] datm;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Requesters: index 0 = imem, 1 = dmem
  bit           r_act[2];
  int           r_gap[2];
  bit           got[2];
  logic [11:0]  r_adr[2];
  logic [127:0] r_dat[2];
  logic [15:0]  r_sel[2];
  bit           r_we[2];
  bit           gen_en = 1'b0;

  assign imem_bus.ADR   = r_adr[0];
  assign imem_bus.DAT_M = '0;
  assign imem_bus.SEL   = '0;
  assign imem_bus.WE    = 1'b0;
  assign imem_bus.CYC   = r_act[0];
  assign imem_bus.STB   = r_act[0];
  assign dmem_bus.ADR   = r_adr[1];
  assign dmem_bus.DAT_M = r_dat[1];
  assign dmem_bus.SEL   = r_sel[1];
  assign dmem_bus.WE    = r_we[1];
  assign dmem_bus.CYC   = r_act[1];
  assign dmem_bus.STB   = r_act[1];

  initial begin
    for (int p = 0; p < 2; p++) begin
      r_act[p] = 1'b0; r_gap[p] = 0; got[p] = 1'b0;
      r_adr[p] = '0; r_dat[p] = '0; r_sel[p] = '0; r_we[p] = 1'b0;
    end
    forever begin
      @(negedge clk); #3;
      got[0] = (imem_bus.ACK === 1'b1) || (imem_bus.RTY === 1'b1);
      got[1] = (dmem_bus.ACK === 1'b1) || (dmem_bus.RTY === 1'b1);
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (r_act[p] && got[p]) begin
          r_act[p] = 1'b0;
          r_gap[p] = $urandom_range(0, 3);
        end else if (r_act[p] && $urandom_range(0, 39) == 0) begin
          r_act[p] = 1'b0;
          r_gap[p] = 1;
        end else if (!r_act[p] && r_gap[p] > 0) begin
          r_gap[p]--;
        end
        if (!r_act[p] && gen_en && r_gap[p] == 0) begin
          r_act[p] = 1'b1;
          r_adr[p] = 12'($urandom);
          r_dat[p] = {$urandom, $urandom, $urandom, $urandom};
          r_sel[p] = 16'($urandom);
          r_we[p]  = 1'($urandom);
        end
      end
    end
  end

  // Memory responder plus reference model, both driven from the model's plan
  logic         m_ack = 1'b0, m_rty = 1'b0;
  logic [127:0] m_dat = '0;
  assign mem_bus.ACK   = m_ack;
  assign mem_bus.RTY   = m_rty;
  assign mem_bus.DAT_S = m_dat;

  int m_gnt  = -1;
  int m_end  = 0;
  int m_ackc = -1;
  bit m_last = 1'b0;
  bit m_wd   = 1'b0;
  bit m_kack = 1'b0, m_krty = 1'b0;

  initial begin
    bit   rq[2];
    bit   exp_cyc;
    int   lat, k, w;
    exp_t e;
    forever begin
      @(negedge clk);
      m_ack = (cyc == m_ackc) && m_kack;
      m_rty = (cyc == m_ackc) && m_krty;
      #1;
      rq[0] = imem_bus.CYC && imem_bus.STB;
      rq[1] = dmem_bus.CYC && dmem_bus.STB;
      if (rst) begin
        m_gnt = -1; m_last = 1'b0; m_ackc = -1;
        while (exp_q.size() > 0 && exp_q[$].cycle > cyc) void'(exp_q.pop_back());
      end else if (m_gnt >= 0) begin
        if (m_gnt == 0)
          chk("idle_port_quiet", {dmem_bus.ACK, dmem_bus.RTY, dmem_bus.DAT_S}, '0);
        else
          chk("idle_port_quiet", {imem_bus.ACK, imem_bus.RTY, imem_bus.DAT_S}, '0);
        exp_cyc = rq[m_gnt] && !(cyc == m_end && m_wd);
        chk("mem_cyc", {mem_bus.CYC, mem_bus.STB}, {exp_cyc, exp_cyc});
        if (exp_cyc) chk("mem_adr", mem_bus.ADR, r_adr[m_gnt]);
        if (!rq[m_gnt]) begin
          if (exp_q.size() > 0 && exp_q[$].cycle >= cyc) void'(exp_q.pop_back());
          m_gnt = -1; m_ackc = -1;
        end else if (cyc == m_end) begin
          m_gnt = -1;
        end
      end else begin
        chk("idle_outputs", {mem_bus.CYC, mem_bus.STB, imem_bus.ACK, imem_bus.RTY,
                             dmem_bus.ACK, dmem_bus.RTY}, '0);
        chk("idle_dat_s", imem_bus.DAT_S | dmem_bus.DAT_S, '0);
        if (rq[0] || rq[1]) begin
          w      = (rq[0] && rq[1]) ? (m_last ? 0 : 1) : (rq[1] ? 1 : 0);
          m_last = (w == 1);
          m_gnt  = w;
          m_dat  = {$urandom, $urandom, $urandom, $urandom};
          lat    = $urandom_range(0, 5);
          k      = $urandom_range(0, 3);
          if (lat <= TIMEOUT - 1) begin
            m_end  = cyc + 1 + lat;
            m_ackc = m_end;
            m_wd   = 1'b0;
            m_kack = (k != 2);
            m_krty = (k >= 2);
          end else begin
            m_end  = cyc + TIMEOUT;
            m_ackc = -1;
            m_wd   = 1'b1;
            m_kack = 1'b0;
            m_krty = 1'b0;
          end
          e.cycle = m_end;
          e.port  = w;
          e.ack   = m_kack;
          e.rty   = m_krty || m_wd;
          e.wd    = m_wd;
          e.data  = m_dat;
          e.adr   = r_adr[w];
          e.we    = (w == 1) ? r_we[1] : 1'b0;
          e.sel   = (w == 1) ? r_sel[1] : 16'hFFFF;
          e.datm  = (w == 1) ? r_dat[1] : '0;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever either requester sees ACK/RTY
  initial begin
    exp_t e;
    int   port;
    forever begin
      @(negedge clk); #2;
      if (imem_bus.ACK || imem_bus.RTY || dmem_bus.ACK || dmem_bus.RTY) begin
        chk("single_responder", {(imem_bus.ACK || imem_bus.RTY), (dmem_bus.ACK || dmem_bus.RTY)} == 2'b11, 0);
        port = (dmem_bus.ACK || dmem_bus.RTY) ? 1 : 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_response", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_cycle", cyc, e.cycle);
          chk("resp_port", port, e.port);
          if (port == 0) begin
            chk("resp_ack_rty", {imem_bus.ACK, imem_bus.RTY}, {e.ack, e.rty});
            chk("resp_data", imem_bus.DAT_S, e.data);
          end else begin
            chk("resp_ack_rty", {dmem_bus.ACK, dmem_bus.RTY}, {e.ack, e.rty});
            chk("resp_data", dmem_bus.DAT_S, e.data);
          end
          if (e.wd) begin
            chk("wd_mem_cyc", {mem_bus.CYC, mem_bus.STB}, 2'b00);
          end else begin
            chk("resp_mem_cyc", {mem_bus.CYC, mem_bus.STB}, 2'b11);
            chk("resp_mem_adr", mem_bus.ADR, e.adr);
            chk("resp_mem_we_sel", {mem_bus.WE, mem_bus.SEL}, {e.we, e.sel});
            chk("resp_mem_dat_m", mem_bus.DAT_M, e.datm);
          end
        end
      end
      while (exp_q.size() > 0 && exp_q[0].cycle < cyc) begin
        e = exp_q.pop_front();
        chk("missing_response_port", e.port + 10, e.port);
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    gen_en = 1'b1;
    repeat (200) @(posedge clk);
    // Reset in the middle of dmem grants
    for (int n = 0; n < 4; n++) begin
      for (int t = 0; t < 400; t++) begin
        @(posedge clk); #1;
        if (m_gnt == 1 && m_end > cyc) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          break;
        end
      end
      repeat (100) @(posedge clk);
    end
    repeat (1500) @(posedge clk);
    gen_en = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_mem_arbiter.md
Name: wb_mem_arbiter

Overview:
- Consumes the CPU's two wishbone master ports (imem and dmem) and merges them onto a single wishbone master port toward the unified 128-bit-line main memory.
- Two slave sides, one master side; one transaction in flight at a time.
- Round-robin arbitration with a per-transaction watchdog that converts a hung memory access into a retry to the requester.

Parameters:
TIMEOUT, 64, cycles a granted transaction may wait for mem ACK/RTY before forced retry; 0 disables watchdog
CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
imem_ADR  input  12  imem line address (byte addr [15:4])
imem_CYC  input  1  imem cycle valid
imem_STB  input  1  imem strobe
imem_DAT_S  output  128  read line to imem
imem_ACK  output  1  imem transaction complete
imem_RTY  output  1  imem retry
dmem_ADR  input  12  dmem line address
dmem_DAT_M  input  128  dmem write line
dmem_SEL  input  16  dmem byte enables
dmem_WE  input  1  dmem write
dmem_CYC  input  1  dmem cycle valid
dmem_STB  input  1  dmem strobe
dmem_DAT_S  output  128  read line to dmem
dmem_ACK  output  1  dmem transaction complete
dmem_RTY  output  1  dmem retry
mem_ADR  output  12  memory line address
mem_DAT_M  output  128  memory write line
mem_SEL  output  16  memory byte enables
mem_WE  output  1  memory write
mem_CYC  output  1  memory cycle valid
mem_STB  output  1  memory strobe
mem_DAT_S  input  128  memory read line
mem_ACK  input  1  memory complete
mem_RTY  input  1  memory retry

Behaviour:
- Request: req_i = imem_CYC & imem_STB; req_d = dmem_CYC & dmem_STB.
- State register: IDLE, GNT_I, GNT_D. Additional registers: last (0=imem, 1=dmem) and wd_cnt[CNT_W].
- Reset (rst high at a clock edge): state=IDLE, last=imem (so dmem wins the first tie), wd_cnt=0.
- IDLE outputs: all mem_* and all slave ACK/RTY = 0; DAT_S outputs = 0.
- Transitions out of IDLE:
  - Only req_i -> GNT_I.
  - Only req_d -> GNT_D.
  - Both requesting -> the port not equal to last.
  - On entering a grant state: last updated to that port, wd_cnt cleared.
- Grant outputs (combinational):
  - mem_ADR/CYC/STB = granted port's signals.
  - imem grant: mem_WE=0, mem_SEL=16'hFFFF, mem_DAT_M=0.
  - dmem grant: mem_WE, mem_SEL, mem_DAT_M pass through from dmem.
  - granted DAT_S = mem_DAT_S, granted ACK = mem_ACK, granted RTY = mem_RTY | wd_fire.
  - Non-granted port: ACK=RTY=0, DAT_S=0.
- Grant exits:
  - mem_ACK or mem_RTY -> IDLE next cycle.
  - Granted requester drops CYC or STB (abort): mem_CYC/STB follow it low the same cycle; -> IDLE next cycle, no ACK/RTY.
- Watchdog:
  - In a grant state with TIMEOUT != 0, wd_cnt increments each cycle without mem_ACK/mem_RTY.
  - wd_fire = (wd_cnt == TIMEOUT-1) & ~mem_ACK & ~mem_RTY.
  - On wd_fire: requester RTY=1 for that cycle, mem_CYC/STB forced 0 that cycle, -> IDLE.
  - A mem_ACK in the fire cycle wins (normal completion, no RTY).
- Latency:
  - Request first visible at edge n -> grant at cycle n+1.
  - Earliest ACK at n+1 (memory acking combinationally).
  - IDLE at n+2; minimum back-to-back spacing is 2 cycles per transaction.
- Fairness: with both ports requesting continuously, grants strictly alternate D, I, D, I, ...
- Ignored inputs: a request arriving while the other port is granted waits (its ACK/RTY held 0); no input outside the granted port affects outputs.
- Reset mid-transaction: next cycle IDLE with all mem outputs 0; the in-flight requester receives no ACK.
- Simultaneous mem_ACK and mem_RTY: ACK forwarded and RTY forwarded; requester interprets; arbiter returns to IDLE.
- Address/data are not registered: requesters must hold ADR/DAT_M/SEL/WE stable until ACK/RTY.

Test Plan:
- imem alone reads ADR=12'h123; mem acks 3 cycles after grant with DAT_S=128'hA5..A5 -> mem_ADR=12'h123, mem_WE=0, mem_SEL=16'hFFFF, imem_ACK=1 with A5 data in that cycle, dmem_ACK=0.
- dmem write ADR=12'h040, SEL=16'h0030, DAT_M word2=16'hBEEF, WE=1 -> mem_* match exactly; dmem_ACK on mem_ACK; state IDLE next cycle.
- Both request from reset for 4 transactions, mem acks immediately -> grant order D, I, D, I; each grant 2 cycles apart.
- Granted imem, mem_RTY=1 -> imem_RTY=1 same cycle, imem_ACK=0; pending dmem granted the following arbitration cycle.
- TIMEOUT=4, mem silent -> imem_RTY=1 exactly 4 cycles after grant, mem_CYC=0 that cycle; repeated with mem_ACK in the 4th cycle -> ACK, no RTY.
- rst asserted during GNT_D -> next cycle mem_CYC=0, dmem_ACK=0; after release, simultaneous requests grant dmem first.
